// File: rtl/gshare_counter_table.sv
// gshare PHT of 2-bit saturating counters, self-initialised after reset.
// Optional BPRED_STATS_EN adds branch and mispredict counters.
module gshare_counter_table #(
    parameter int BPRED_WIDTH = 9
) (
    input  logic                   i_Clk,
    input  logic                   i_Reset,
    input  logic                   i_DEC_Is_Branch,
    input  logic [31:0]            i_DEC_PC,
    input  logic [BPRED_WIDTH-1:0] i_Global_History,
    input  logic                   i_ALU_Branch_Valid,
    input  logic                   i_ALU_Branch_Outcome,
    input  logic [BPRED_WIDTH-1:0] i_ALU_Index,
`ifdef BPRED_STATS_EN
    input  logic                   i_ALU_Prediction,
    output logic [31:0]            o_Branch_Count,
    output logic [31:0]            o_Mispredict_Count,
`endif
    output logic                   o_Prediction,
    output logic [BPRED_WIDTH-1:0] o_Index,
    output logic                   o_Ready
);

    localparam int DEPTH = 1 << BPRED_WIDTH;

    typedef enum logic {
        S_INIT,
        S_READY
    } state_t;

    state_t                 state_q, state_d;
    logic [BPRED_WIDTH-1:0] ptr_q, ptr_d;
    logic [1:0]             pht [DEPTH];
    logic                   wr_en;
    logic [BPRED_WIDTH-1:0] wr_addr;
    logic [1:0]             wr_data;
    logic [1:0]             cur_ctr;
    logic                   upd_en;
    logic                   unused_pc;

    assign unused_pc = ^{i_DEC_PC[31:BPRED_WIDTH+2], i_DEC_PC[1:0]};

    assign o_Index      = i_DEC_PC[BPRED_WIDTH+1:2] ^ i_Global_History;
    assign o_Ready      = (state_q == S_READY);
    assign o_Prediction = i_DEC_Is_Branch && o_Ready && pht[o_Index][1];
    assign upd_en       = o_Ready && i_ALU_Branch_Valid;
    assign cur_ctr      = pht[i_ALU_Index];

    always_ff @(posedge i_Clk or negedge i_Reset) begin
        if (!i_Reset) begin
            state_q <= S_INIT;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        wr_en   = 1'b0;
        wr_addr = i_ALU_Index;
        wr_data = cur_ctr;
        unique case (state_q)
            S_INIT: begin
                wr_en   = 1'b1;
                wr_addr = ptr_q;
                wr_data = 2'b01;
                ptr_d   = ptr_q + 1'b1;
                if (ptr_q == '1) state_d = S_READY;
            end
            S_READY: begin
                if (upd_en) begin
                    wr_en = 1'b1;
                    if (i_ALU_Branch_Outcome)
                        wr_data = (cur_ctr == 2'b11) ? cur_ctr : cur_ctr + 2'd1;
                    else
                        wr_data = (cur_ctr == 2'b00) ? cur_ctr : cur_ctr - 2'd1;
                end
            end
            default: ;
        endcase
    end

    // No reset on the array so it can map onto a RAM; the FSM initialises it.
    always_ff @(posedge i_Clk) begin
        if (wr_en) pht[wr_addr] <= wr_data;
    end

`ifdef BPRED_STATS_EN
    always_ff @(posedge i_Clk or negedge i_Reset) begin
        if (!i_Reset) begin
            o_Branch_Count     <= '0;
            o_Mispredict_Count <= '0;
        end else if (upd_en) begin
            if (o_Branch_Count != '1)
                o_Branch_Count <= o_Branch_Count + 32'd1;
            if ((i_ALU_Prediction != i_ALU_Branch_Outcome) &&
                (o_Mispredict_Count != '1))
                o_Mispredict_Count <= o_Mispredict_Count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_gshare_counter_table.sv
// Scoreboard bench for gshare_counter_table with a counter-array model.
// Expectations are queued by stimulus and checked by a negedge monitor.
module tb_gshare_counter_table;

    localparam int W     = 9;
    localparam int DEPTH = 1 << W;

    logic          i_Clk = 1'b0;
    logic          i_Reset = 1'b0;
    logic          i_DEC_Is_Branch = 1'b0;
    logic [31:0]   i_DEC_PC = '0;
    logic [W-1:0]  i_Global_History = '0;
    logic          i_ALU_Branch_Valid = 1'b0;
    logic          i_ALU_Branch_Outcome = 1'b0;
    logic [W-1:0]  i_ALU_Index = '0;
    logic          o_Prediction;
    logic [W-1:0]  o_Index;
    logic          o_Ready;
`ifdef BPRED_STATS_EN
    logic          i_ALU_Prediction = 1'b0;
    logic [31:0]   o_Branch_Count;
    logic [31:0]   o_Mispredict_Count;
`endif

    gshare_counter_table #(.BPRED_WIDTH(W)) dut (
        .i_Clk                (i_Clk),
        .i_Reset              (i_Reset),
        .i_DEC_Is_Branch      (i_DEC_Is_Branch),
        .i_DEC_PC             (i_DEC_PC),
        .i_Global_History     (i_Global_History),
        .i_ALU_Branch_Valid   (i_ALU_Branch_Valid),
        .i_ALU_Branch_Outcome (i_ALU_Branch_Outcome),
        .i_ALU_Index          (i_ALU_Index),
`ifdef BPRED_STATS_EN
        .i_ALU_Prediction     (i_ALU_Prediction),
        .o_Branch_Count       (o_Branch_Count),
        .o_Mispredict_Count   (o_Mispredict_Count),
`endif
        .o_Prediction         (o_Prediction),
        .o_Index              (o_Index),
        .o_Ready              (o_Ready)
    );

    always #5 i_Clk = ~i_Clk;

    typedef struct {
        logic [W-1:0] idx;
        logic         pred;
        logic         rdy;
        logic [31:0]  bc;
        logic [31:0]  mc;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model
    int   ctr[DEPTH];
    bit   m_ready = 0;
    int   m_edges = 0;
    longint m_bc = 0;
    longint m_mc = 0;

    function automatic int sat_inc(int v, bit up);
        if (up) return (v < 3) ? v + 1 : 3;
        return (v > 0) ? v - 1 : 0;
    endfunction

    // Drive one cycle (caller is just after a posedge), queue expectation,
    // then advance the model across the following edge.
    task automatic cycle(input bit rst_n, input bit br, input logic [31:0] pc,
                         input logic [W-1:0] ghr, input bit v, input bit outc,
                         input logic [W-1:0] aidx, input bit apred);
        exp_t e;
        int   li;
        i_Reset = rst_n;
        i_DEC_Is_Branch = br;
        i_DEC_PC = pc;
        i_Global_History = ghr;
        i_ALU_Branch_Valid = v;
        i_ALU_Branch_Outcome = outc;
        i_ALU_Index = aidx;
`ifdef BPRED_STATS_EN
        i_ALU_Prediction = apred;
`endif
        if (!rst_n) begin
            m_ready = 0;
            m_edges = 0;
            m_bc = 0;
            m_mc = 0;
        end
        li = ((pc / 4) % DEPTH) ^ int'(ghr);
        e.idx  = W'(li);
        e.rdy  = m_ready;
        e.pred = br && m_ready && (ctr[li] >= 2);
        e.bc   = m_bc[31:0];
        e.mc   = m_mc[31:0];
        q.push_back(e);
        @(posedge i_Clk);
        #1;
        if (!rst_n) begin
            m_edges = 0;
        end else if (!m_ready) begin
            m_edges++;
            if (m_edges == DEPTH) begin
                m_ready = 1;
                foreach (ctr[k]) ctr[k] = 1;
            end
        end else if (v) begin
            ctr[aidx] = sat_inc(ctr[aidx], outc);
            if (m_bc < 64'hFFFF_FFFF) m_bc++;
            if (apred != outc && m_mc < 64'hFFFF_FFFF) m_mc++;
        end
    endtask

    task automatic look(input logic [31:0] pc, input logic [W-1:0] ghr);
        cycle(1, 1, pc, ghr, 0, 0, '0, 0);
    endtask

    task automatic train(input logic [W-1:0] idx, input bit outc);
        cycle(1, 0, 32'h0, '0, 1, outc, idx, outc);
    endtask

    task automatic run_init(input bit with_updates);
        for (int i = 0; i < DEPTH + 1; i++)
            cycle(1, 1'($urandom), $urandom, W'($urandom),
                  with_updates ? 1'($urandom) : 1'b0, 1'b1,
                  (i % 4 == 0) ? W'(4) : W'($urandom), 1'($urandom));
    endtask

    always @(negedge i_Clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            tests++;
            if (o_Index !== e.idx) begin
                fails++;
                $display("FAIL index got %h exp %h", o_Index, e.idx);
            end
            tests++;
            if (o_Ready !== e.rdy) begin
                fails++;
                $display("FAIL ready got %b exp %b", o_Ready, e.rdy);
            end
            tests++;
            if (o_Prediction !== e.pred) begin
                fails++;
                $display("FAIL pred idx %h got %b exp %b", e.idx, o_Prediction, e.pred);
            end
`ifdef BPRED_STATS_EN
            tests++;
            if (o_Branch_Count !== e.bc) begin
                fails++;
                $display("FAIL branch_count got %0d exp %0d", o_Branch_Count, e.bc);
            end
            tests++;
            if (o_Mispredict_Count !== e.mc) begin
                fails++;
                $display("FAIL mispredict_count got %0d exp %0d", o_Mispredict_Count, e.mc);
            end
`endif
        end
    end

    initial begin
        foreach (ctr[k]) ctr[k] = 1;
        @(posedge i_Clk);
        #1;
        cycle(0, 1, 32'h00400010, '0, 1, 1, 9'h004, 0);
        cycle(0, 1, 32'h00400010, '0, 1, 1, 9'h004, 0);
        run_init(1);
        look(32'h00400010, 9'h000);
        train(9'h004, 1);
        train(9'h004, 1);
        look(32'h00400010, 9'h000);
        train(9'h004, 1);
        look(32'h00400010, 9'h000);
        for (int i = 0; i < 5; i++) begin
            train(9'h004, 0);
            look(32'h00400010, 9'h000);
        end
        look(32'h00400010, 9'h1FF);
        train(9'h1FB, 1);
        train(9'h1FB, 1);
        look(32'h00400010, 9'h1FF);
        look(32'h00400010, 9'h000);
        train(9'h004, 1);
        cycle(1, 1, 32'h00400010, '0, 1, 1, 9'h004, 1);
        look(32'h00400010, 9'h000);
        for (int i = 0; i < 1500; i++)
            cycle(1, 1'($urandom), $urandom, W'($urandom), 1'($urandom),
                  1'($urandom), W'($urandom_range(0, 7)), 1'($urandom));
        train(9'h004, 1);
        train(9'h004, 1);
        train(9'h004, 1);
        look(32'h00400010, 9'h000);
        cycle(0, 1, 32'h00400010, '0, 0, 0, '0, 0);
        run_init(1);
        look(32'h00400010, 9'h000);
        cycle(1, 0, 32'h0, '0, 1, 1, 9'h010, 1);
        cycle(1, 0, 32'h0, '0, 1, 1, 9'h011, 0);
        cycle(1, 0, 32'h0, '0, 1, 0, 9'h012, 0);
        look(32'h00400010, 9'h000);
        repeat (2) @(posedge i_Clk);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain got %0d pending exp 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
